// File: rtl/urcpu_pkg.sv
// Shared URCPU datapath constants and types for the general-purpose register file.
package urcpu_pkg;

   localparam int REG_WIDTH  = 20;
   localparam int REG_COUNT  = 16;
   localparam int REG_ADDR_W = 4;

   typedef logic [REG_WIDTH-1:0]  reg_word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_bank_read_port.sv
// One asynchronous read port of the register bank: a DEPTH:1 mux over the
// stored registers. Optional macro REGBANK_BYPASS_EN adds write-to-read
// forwarding, so a same-cycle write to the addressed register shows the
// incoming data instead of the stored value.
module register_bank_read_port #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 16
) (
   input  logic [WIDTH-1:0]         regs [DEPTH],
   input  logic [$clog2(DEPTH)-1:0] raddr,
`ifdef REGBANK_BYPASS_EN
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
`endif
   output logic [WIDTH-1:0]         rdata
);

   // Select the addressed register, forwarding pending write data when enabled.
   always_comb begin
      rdata = regs[raddr];
`ifdef REGBANK_BYPASS_EN
      // Reset wins over forwarding: the array is already cleared, and the
      // incoming write is going to be discarded anyway.
      if (rst) begin
         rdata = '0;
      end else if (we && (waddr == raddr)) begin
         rdata = wdata;
      end
`endif
   end

endmodule

// File: rtl/register_bank_16x20.sv
// URCPU general-purpose register file: DEPTH registers of WIDTH bits, one
// synchronous write port, two combinational read ports. All registers are
// writable (R0 is not hardwired). Optional macro REGBANK_BYPASS_EN enables
// same-cycle write-to-read forwarding on both read ports.
module register_bank_16x20
   import urcpu_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int DEPTH = REG_COUNT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     WE,
   input  logic [WIDTH-1:0]         in,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [$clog2(DEPTH)-1:0] raddr0,
   input  logic [$clog2(DEPTH)-1:0] raddr1,
   output logic [WIDTH-1:0]         out0,
   output logic [WIDTH-1:0]         out1
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];

   // Write decode: only the addressed register takes the new value when enabled.
   always_comb begin
      regs_d = regs_q;
      if (WE) begin
         regs_d[waddr] = in;
      end
   end

   // Storage array; reset clears everything immediately and discards any coincident write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   register_bank_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_read_port0 (
      .regs  (regs_q),
      .raddr (raddr0),
`ifdef REGBANK_BYPASS_EN
      .rst   (rst),
      .we    (WE),
      .waddr (waddr),
      .wdata (in),
`endif
      .rdata (out0)
   );

   register_bank_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_read_port1 (
      .regs  (regs_q),
      .raddr (raddr1),
`ifdef REGBANK_BYPASS_EN
      .rst   (rst),
      .we    (WE),
      .waddr (waddr),
      .wdata (in),
`endif
      .rdata (out1)
   );

endmodule

// File: tb/tb_register_bank_16x20.sv
// Self-checking bench for register_bank_16x20 (default build and REGBANK_BYPASS_EN build).
module tb_register_bank_16x20;

   localparam int W = 20;
   localparam int D = 16;

   logic         clk;
   logic         rst;
   logic         we;
   logic [W-1:0] wdata;
   logic [3:0]   waddr;
   logic [3:0]   raddr0;
   logic [3:0]   raddr1;
   logic [W-1:0] out0;
   logic [W-1:0] out1;

   logic [W-1:0] model [D];
   int n_checks;
   int n_fail;

   register_bank_16x20 dut (
      .clk    (clk),
      .rst    (rst),
      .WE     (we),
      .in     (wdata),
      .waddr  (waddr),
      .raddr0 (raddr0),
      .raddr1 (raddr1),
      .out0   (out0),
      .out1   (out1)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; return 1 time unit after it so inputs change away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Driver: single write through one edge, then write disabled.
   task automatic do_write(input logic [3:0] a, input logic [W-1:0] d);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      step();
      we    = 1'b0;
      model[a] = d;
   endtask

   task automatic clear_model();
      for (int i = 0; i < D; i++) model[i] = '0;
   endtask

   task automatic test_reset();
      do_write(4'd1, 20'h5A5A5);
      do_write(4'd9, 20'h0F0F0);
      raddr0 = 4'd1;
      raddr1 = 4'd9;
      #1;
      n_checks++;
      if (out0 !== 20'h5A5A5) begin
         n_fail++;
         $display("FAIL reset_prefill out0 got %05h want %05h", out0, 20'h5A5A5);
      end
      // Assert reset mid-cycle: no clock edge before the first check.
      rst = 1'b1;
      #1;
      clear_model();
      n_checks++;
      if (out0 !== 20'h0 || out1 !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_immediate out0 %05h out1 %05h want 00000", out0, out1);
      end
      for (int i = 0; i < D; i++) begin
         raddr0 = i[3:0];
         raddr1 = 4'(D - 1 - i);
         #1;
         n_checks++;
         if (out0 !== 20'h0 || out1 !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_all addr %0d out0 %05h out1 %05h want 00000", i, out0, out1);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_write_read();
      do_write(4'd3, 20'hABCDE);
      raddr0 = 4'd3;
      raddr1 = 4'd3;
      #1;
      n_checks++;
      if (out0 !== 20'hABCDE || out1 !== 20'hABCDE) begin
         n_fail++;
         $display("FAIL write_read_r3 out0 %05h out1 %05h want abcde", out0, out1);
      end
      raddr0 = 4'd2;
      raddr1 = 4'd4;
      #1;
      n_checks++;
      if (out0 !== 20'h0 || out1 !== 20'h0) begin
         n_fail++;
         $display("FAIL write_read_neighbours r2 %05h r4 %05h want 00000", out0, out1);
      end
   endtask

   task automatic test_write_disable();
      do_write(4'd5, 20'h12345);
      we    = 1'b0;
      waddr = 4'd5;
      wdata = 20'hFFFFF;
      for (int i = 0; i < 4; i++) step();
      raddr0 = 4'd5;
      raddr1 = 4'd5;
      #1;
      n_checks++;
      if (out0 !== 20'h12345 || out1 !== 20'h12345) begin
         n_fail++;
         $display("FAIL write_disable r5 out0 %05h out1 %05h want 12345", out0, out1);
      end
   endtask

   task automatic test_extremes();
      do_write(4'd15, 20'hFFFFF);
      do_write(4'd0, 20'h00001);
      raddr0 = 4'd15;
      raddr1 = 4'd0;
      #1;
      n_checks++;
      if (out0 !== 20'hFFFFF || out1 !== 20'h00001) begin
         n_fail++;
         $display("FAIL extremes r15 %05h want fffff r0 %05h want 00001", out0, out1);
      end
      raddr0 = 4'd0;
      raddr1 = 4'd15;
      #1;
      n_checks++;
      if (out0 !== 20'h00001 || out1 !== 20'hFFFFF) begin
         n_fail++;
         $display("FAIL extremes_swap r0 %05h want 00001 r15 %05h want fffff", out0, out1);
      end
   endtask

   task automatic test_collision();
      logic [W-1:0] exp_pre;
      do_write(4'd7, 20'h11111);
      we     = 1'b1;
      waddr  = 4'd7;
      wdata  = 20'h22222;
      raddr0 = 4'd7;
      raddr1 = 4'd6;
`ifdef REGBANK_BYPASS_EN
      exp_pre = 20'h22222;
`else
      exp_pre = 20'h11111;
`endif
      #1;
      n_checks++;
      if (out0 !== exp_pre || out1 !== model[6]) begin
         n_fail++;
         $display("FAIL collision_pre out0 %05h want %05h out1 %05h want %05h", out0, exp_pre, out1, model[6]);
      end
      step();
      we = 1'b0;
      model[7] = 20'h22222;
      #1;
      n_checks++;
      if (out0 !== 20'h22222) begin
         n_fail++;
         $display("FAIL collision_post out0 %05h want 22222", out0);
      end
   endtask

   task automatic test_random();
      logic [3:0]   a;
      logic [W-1:0] d;
      for (int i = 0; i < 25; i++) begin
         a = 4'($urandom_range(0, D - 1));
         d = W'($urandom_range(0, (1 << W) - 1));
         do_write(a, d);
      end
      for (int i = 0; i < 25; i++) begin
         raddr0 = 4'($urandom_range(0, D - 1));
         raddr1 = 4'($urandom_range(0, D - 1));
         waddr  = 4'($urandom_range(0, D - 1));
         wdata  = W'($urandom_range(0, (1 << W) - 1));
         #1;
         n_checks++;
         if (out0 !== model[raddr0] || out1 !== model[raddr1]) begin
            n_fail++;
            $display("FAIL random_read cyc %0d a0 %0d out0 %05h want %05h a1 %0d out1 %05h want %05h",
                     i, raddr0, out0, model[raddr0], raddr1, out1, model[raddr1]);
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      do_write(4'd10, 20'hCAFE0);
      raddr0 = 4'd10;
      raddr1 = 4'd3;
      #1;
      n_checks++;
      if (out0 !== 20'hCAFE0) begin
         n_fail++;
         $display("FAIL async_prefill out0 %05h want cafe0", out0);
      end
      rst = 1'b1;
      #1;
      clear_model();
      n_checks++;
      if (out0 !== 20'h0 || out1 !== 20'h0) begin
         n_fail++;
         $display("FAIL async_reset_immediate out0 %05h out1 %05h want 00000", out0, out1);
      end
      // A write held across an edge during reset must be discarded and not forwarded.
      we    = 1'b1;
      waddr = 4'd10;
      wdata = 20'h77777;
      #1;
      n_checks++;
      if (out0 !== 20'h0) begin
         n_fail++;
         $display("FAIL async_reset_no_forward out0 %05h want 00000", out0);
      end
      step();
      @(negedge clk);
      we  = 1'b0;
      rst = 1'b0;
      #1;
      n_checks++;
      if (out0 !== 20'h0) begin
         n_fail++;
         $display("FAIL async_reset_write_discarded out0 %05h want 00000", out0);
      end
      do_write(4'd10, 20'h13579);
      #1;
      n_checks++;
      if (out0 !== 20'h13579) begin
         n_fail++;
         $display("FAIL async_reset_resume out0 %05h want 13579", out0);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst    = 1'b1;
      we     = 1'b0;
      wdata  = '0;
      waddr  = '0;
      raddr0 = '0;
      raddr1 = '0;
      clear_model();
      step();
      step();
      @(negedge clk);
      rst = 1'b0;
      step();

      test_reset();
      test_write_read();
      test_write_disable();
      test_extremes();
      test_collision();
      test_random();
      test_async_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
